// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner with dead-time and LZ blanking.
// Ports: clk, reset(async high), digits, dp_in, digit_en, lz_suppress, blank -> an, seg, dp, digit_idx, frame_tick.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b1,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CW = $clog2(REFRESH_DIV)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    input  logic                    blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_tick
);

    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_POL = {7{ACTIVE_LOW}};

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          last_cnt;
    logic          last_idx;

    logic [NUM_DIGITS-1:0] supp;
    logic                  zrun;
    logic [3:0]            sel_nib;
    logic                  sel_en;
    logic                  sel_dp;
    logic                  sel_sup;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_n;
    logic [6:0]            seg_n;
    logic                  dp_n;

    function automatic logic [6:0] hex2seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign last_cnt = (cnt == CW'(REFRESH_DIV - 1));
    assign last_idx = (idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (last_cnt) begin
            cnt <= '0;
            idx <= last_idx ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Walk from the most significant digit down; a digit is suppressed while
    // every nibble at or above it is zero. Digit 0 always shows.
    always_comb begin
        zrun = 1'b1;
        supp = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zrun    = zrun && (digits[4*i +: 4] == 4'h0);
            supp[i] = lz_suppress && zrun && (i != 0);
        end
    end

    always_comb begin
        sel_nib = 4'h0;
        sel_en  = 1'b0;
        sel_dp  = 1'b0;
        sel_sup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                sel_nib = digits[4*i +: 4];
                sel_en  = digit_en[i];
                sel_dp  = dp_in[i];
                sel_sup = supp[i];
            end
        end
    end

    // Leading cycles of each slot keep all anodes dark to avoid ghosting.
    assign lit   = (cnt >= CW'(BLANK_CYCLES)) && !blank && sel_en && !sel_sup;
    assign an_n  = lit ? (NUM_DIGITS'(1) << idx) : '0;
    assign seg_n = lit ? hex2seg(sel_nib) : 7'h00;
    assign dp_n  = lit && sel_dp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= AN_POL;
            seg        <= SEG_POL;
            dp         <= ACTIVE_LOW;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_n ^ AN_POL;
            seg        <= seg_n ^ SEG_POL;
            dp         <= dp_n ^ ACTIVE_LOW;
            digit_idx  <= idx;
            frame_tick <= last_cnt && last_idx;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: 4-digit active-low and 1-digit active-high.
// Ports: none.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  en;
    logic        lz;
    logic        blank;
    logic [3:0]  an4;
    logic [6:0]  seg4;
    logic        dp4;
    logic [1:0]  idx4;
    logic        ft4;

    logic [3:0]  d1;
    logic        dp1;
    logic        en1;
    logic        an1;
    logic [6:0]  seg1;
    logic        dpo1;
    logic        idx1;
    logic        ft1;

    int n_chk = 0;
    int n_pass = 0;

    logic [6:0] seg1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)
    ) u4 (
        .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in),
        .digit_en(en), .lz_suppress(lz), .blank(blank),
        .an(an4), .seg(seg4), .dp(dp4), .digit_idx(idx4), .frame_tick(ft4)
    );

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(1), .REFRESH_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1'b0)
    ) u1 (
        .clk(clk), .reset(reset), .digits(d1), .dp_in(dp1),
        .digit_en(en1), .lz_suppress(1'b0), .blank(1'b0),
        .an(an1), .seg(seg1), .dp(dpo1), .digit_idx(idx1), .frame_tick(ft1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full 32-edge frame, starting aligned with cnt=0, idx=0.
    task automatic run_frame(input string tag, input logic [15:0] ea,
                             input logic [27:0] es, input logic [3:0] ed);
        int s;
        int c;
        for (int e = 1; e <= 32; e++) begin
            tick();
            s = (e - 1) / 8;
            c = (e - 1) % 8;
            if (c == 0) begin
                check({tag, "_dead_an"}, an4, 4'hF);
                check({tag, "_dead_seg"}, seg4, 7'h7F);
                check({tag, "_dead_dp"}, dp4, 1'b1);
            end
            if (c == 4) begin
                check({tag, "_an"}, an4, ea[4*s +: 4]);
                check({tag, "_seg"}, seg4, es[7*s +: 7]);
                check({tag, "_dp"}, dp4, ed[s]);
                check({tag, "_idx"}, idx4, s);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_an"}, an4, 4'hF);
        check({tag, "_seg"}, seg4, 7'h7F);
        check({tag, "_dp"}, dp4, 1'b1);
        check({tag, "_idx"}, idx4, 2'd0);
        check({tag, "_ft"}, ft4, 1'b0);
        check({tag, "_an1"}, an1, 1'b0);
        check({tag, "_seg1"}, seg1, 7'h00);
        check({tag, "_dp1"}, dpo1, 1'b0);
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] ea;
        logic [6:0] es;
        int s;
        int c;
        int c1;
        one    = 4'b0001;
        reset  = 1'b1;
        digits = 16'h1234;
        dp_in  = 4'h0;
        en     = 4'hF;
        lz     = 1'b0;
        blank  = 1'b0;
        d1     = 4'hF;
        dp1    = 1'b1;
        en1    = 1'b1;

        #12;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;

        for (int e = 1; e <= 64; e++) begin
            tick();
            s  = ((e - 1) / 8) % 4;
            c  = (e - 1) % 8;
            ea = (c >= 2) ? ~(one << s) : 4'hF;
            es = (c >= 2) ? seg1234[s] : 7'h7F;
            check("scan_an", an4, ea);
            check("scan_seg", seg4, es);
            check("scan_idx", idx4, s);
            check("scan_ft", ft4, (e % 32) == 0);
            c1 = (e - 1) % 4;
            check("one_an", an1, c1 >= 1);
            check("one_seg", seg1, (c1 >= 1) ? 7'h71 : 7'h00);
            check("one_dp", dpo1, c1 >= 1);
            check("one_idx", idx1, 1'b0);
            check("one_ft", ft1, c1 == 3);
        end

        digits = 16'h0070;
        lz     = 1'b1;
        run_frame("lz70", 16'hFFDE, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF);
        digits = 16'h0000;
        run_frame("lz00", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
        lz = 1'b0;
        run_frame("nolz", 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);

        digits = 16'h1234;
        en     = 4'b1011;
        dp_in  = 4'b0010;
        run_frame("endp", 16'h7FDE, {7'h79, 7'h7F, 7'h30, 7'h19}, 4'b1101);

        repeat (12) tick();
        check("pre_blank_an", an4, 4'hD);
        check("pre_blank_dp", dp4, 1'b0);
        blank = 1'b1;
        tick();
        check("blank_an", an4, 4'hF);
        check("blank_dp", dp4, 1'b1);
        check("blank_idx", idx4, 2'd1);
        repeat (18) tick();
        check("blank_ft31", ft4, 1'b0);
        tick();
        check("blank_ft32", ft4, 1'b1);
        check("blank_idx32", idx4, 2'd3);
        check("blank_an32", an4, 4'hF);
        blank = 1'b0;
        en    = 4'hF;

        repeat (21) tick();
        check("mid_an", an4, 4'hB);
        check("mid_seg", seg4, 7'h24);
        check("mid_idx", idx4, 2'd2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("rs1_an", an4, 4'hF);
        check("rs1_idx", idx4, 2'd0);
        check("rs1_an1", an1, 1'b0);
        tick();
        check("rs2_an", an4, 4'hF);
        check("rs2_an1", an1, 1'b1);
        check("rs2_seg1", seg1, 7'h71);
        tick();
        check("rs3_an", an4, 4'hE);
        check("rs3_seg", seg4, 7'h19);
        check("rs3_dp", dp4, 1'b1);
        check("rs3_idx", idx4, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Parametrised time-multiplexed seven-segment scanner. It supersedes the fixed 2-bit anode decoder.
- It holds its own refresh divider and digit index, and drives one-hot anodes for N digits.
- It decodes each digit's hex nibble to segments, with per-digit decimal point, per-digit enable, and leading-zero suppression.
- A programmable anode dead-time removes ghosting.
- It sits between the binary-to-BCD converter output and the board display pins.

Parameters:
- NUM_DIGITS, 4: digits scanned. Legal range 1..16.
- REFRESH_DIV, 100000: clock cycles per digit slot. Must be >= 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off. Must be < REFRESH_DIV.
- ACTIVE_LOW, 1: 1 means an, seg and dp are active-low; 0 means active-high.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- digits, input, 4*NUM_DIGITS: nibble i is digits[4i+3:4i]. Digit NUM_DIGITS-1 is most significant.
- dp_in, input, NUM_DIGITS: decimal point request per digit.
- digit_en, input, NUM_DIGITS: per-digit enable. A disabled digit keeps its slot but stays dark.
- lz_suppress, input, 1: 1 enables leading-zero suppression.
- blank, input, 1: 1 forces all anodes off. Scanning continues.
- an, output, NUM_DIGITS: one-hot anode drive (polarity per ACTIVE_LOW).
- seg, output, 7: segments {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW).
- dp, output, 1: decimal point drive.
- digit_idx, output, clog2(NUM_DIGITS) (min 1): index of the digit currently driven.
- frame_tick, output, 1: one-cycle pulse at the end of each full scan.

Behaviour:
- **Reset (async):** cnt=0, idx=0. an = all inactive, seg = all off, dp = off, digit_idx = 0, frame_tick = 0. Reset mid-slot aborts the slot immediately.
- **Counter:**
  - cnt increments each clk, 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1, cnt wraps to 0 and idx advances.
  - idx wraps NUM_DIGITS-1 -> 0.
  - NUM_DIGITS=1: idx stays 0.
- **Output timing:** all outputs are registered. The values after clock edge k reflect cnt/idx and the inputs sampled before edge k, i.e. 1-cycle latency. digit_idx equals the idx used for that edge.
- **Anode:** the anode for idx is active only when all of the following hold:
  - cnt >= BLANK_CYCLES
  - blank = 0
  - digit_en[idx] = 1
  - digit idx is not suppressed

  Otherwise all anodes are inactive. Never more than one anode is active.
- **Suppression:** when lz_suppress=1, digit i is suppressed if nibble i and every more-significant nibble equal 0. Digit 0 is never suppressed. Nibbles with value > 9 are never zero, so they stop suppression.
- **Segment decode:** hex 0-F. Active-high patterns:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71

  Inverted when ACTIVE_LOW=1.
- **Dark slots:** seg and dp are forced off whenever the anode is inactive.
- **Decimal point:** dp = dp_in[idx], gated identically to the anode. dp is not affected by suppression logic beyond the anode gating.
- **frame_tick:** asserted for the edge reflecting cnt=REFRESH_DIV-1 and idx=NUM_DIGITS-1. Its period is exactly NUM_DIGITS*REFRESH_DIV cycles.
- **Input changes:** changes to digits, dp_in, digit_en, lz_suppress or blank take effect at the next edge. No slot restart, no glitch beyond a single registered update.
- **Index-to-anode mapping:** idx 0 drives an[0], idx 1 drives an[1], and so on. This is consistent with the existing en->an mapping, and the 4-digit case reproduces the 1110/1101/1011/0111 anode sequence.

Test Plan:
- **Reset and first slot:** NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1. Release reset with digits=16'h1234, all enabled.
  - Edges 1-2: an=1111.
  - Edges 3-8: an=1110, seg=~7'h66 (digit 4).
  - Edges 9-10: an=1111.
  - Edges 11-16: an=1101, seg=~7'h4F.
  - Full sequence 1110, 1101, 1011, 0111, repeating.
- **frame_tick:** same config. frame_tick pulses exactly once every 32 cycles, at edge 32, 64, and so on. digit_idx cycles 0,1,2,3.
- **Leading-zero suppression:** digits=16'h0070, lz_suppress=1.
  - Digits 3 and 2 stay dark.
  - Digit 1 shows ~7'h07.
  - Digit 0 shows ~7'h3F.
  - With digits=16'h0000, only digit 0 lights, showing "0".
  - With lz_suppress=0, all four light.
- **Enable, blank and dp:** digit_en=4'b1011, dp_in=4'b0010.
  - Slot 2: an=1111 and seg off.
  - Slot 1: dp=0 (active) only while an[1] is active.
  - Assert blank mid-slot: an=1111 from the next edge. The cnt/idx sequence is unchanged, and frame_tick is still periodic.
- **Async reset mid-slot:** assert reset at cnt=5, idx=2, between clock edges. Outputs go to the reset values immediately. After release, scanning restarts at idx 0, cnt 0.
- **NUM_DIGITS=1, ACTIVE_LOW=0:** an toggles between 0 (blank window) and 1. digit_idx=0 always. Hex F decodes to 7'h71. frame_tick has period REFRESH_DIV.
